// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message feeder.
package sha256_pkg;

    localparam int BLOCK_W  = 512;
    localparam int WORD_W   = 32;
    localparam int DIGEST_W = 256;

    localparam logic [DIGEST_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        FILL,
        START,
        WAIT,
        PADBLK,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/sha256_pad_insert.sv
// Merges the final message word into the block buffer and applies the 0x80
// terminator and (when it fits) the 64-bit length field.
module sha256_pad_insert
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [3:0]         w_idx,
    input  logic [WORD_W-1:0]  last_word,
    input  logic [2:0]         in_bytes,
    input  logic [63:0]        bit_len,
    output logic [BLOCK_W-1:0] blk_out,
    output logic               pad_overflow
);

    logic [2:0] nbytes;
    int         p;

    always_comb begin
        nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        p      = 4 * int'(w_idx) + int'(nbytes);
        blk_out = '0;
        // Bytes before p come from the buffer or the last word; p itself is 0x80.
        for (int b = 0; b < 64; b++) begin
            if (b < p) begin
                if (b / 4 == int'(w_idx))
                    blk_out[511-8*b -: 8] = last_word[31-8*(b%4) -: 8];
                else
                    blk_out[511-8*b -: 8] = blk_in[511-8*b -: 8];
            end else if (b == p) begin
                blk_out[511-8*b -: 8] = 8'h80;
            end
        end
        pad_overflow = (p >= 56);
        if (!pad_overflow)
            blk_out[63:0] = bit_len;
    end

endmodule

// File: rtl/sha256_feeder.sv
// Builds padded 512-bit blocks from a 32-bit word stream, sequences the
// sha256 core block by block and chains H into the final digest.
module sha256_feeder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [2:0]          in_bytes,
    output logic                core_enable,
    output logic [BLOCK_W-1:0]  core_data,
    output logic [DIGEST_W-1:0] core_hash_in,
    input  logic [DIGEST_W-1:0] core_hash,
    input  logic                core_done,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    localparam int CNT_W = LEN_W - 3;

    feeder_state_t        state;
    logic [BLOCK_W-1:0]   blk_buf;
    logic [DIGEST_W-1:0]  h;
    logic [CNT_W-1:0]     byte_cnt;
    logic [3:0]           w_idx;
    logic                 need_pad;
    logic                 final_blk;
    logic                 pad80_owed;
    logic                 done_q;

    logic [2:0]           last_nbytes;
    logic [CNT_W-1:0]     cnt_next;
    logic [63:0]          len_next;
    logic [63:0]          len_cur;
    logic [BLOCK_W-1:0]   pad_blk;
    logic                 pad_overflow;
    logic                 done_rise;

    assign last_nbytes  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign cnt_next     = byte_cnt + CNT_W'(last_nbytes);
    assign len_next     = 64'({cnt_next, 3'b000});
    assign len_cur      = 64'({byte_cnt, 3'b000});
    assign done_rise    = core_done & ~done_q;

    assign in_ready     = (state == FILL);
    assign core_data    = blk_buf;
    assign core_hash_in = h;

    sha256_pad_insert u_pad (
        .blk_in       (blk_buf),
        .w_idx        (w_idx),
        .last_word    (in_data),
        .in_bytes     (in_bytes),
        .bit_len      (len_next),
        .blk_out      (pad_blk),
        .pad_overflow (pad_overflow)
    );

    // Block sequencer; core_enable and digest_valid are single-cycle pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= FILL;
            blk_buf      <= '0;
            h            <= SHA256_IV;
            byte_cnt     <= '0;
            w_idx        <= '0;
            need_pad     <= 1'b0;
            final_blk    <= 1'b0;
            pad80_owed   <= 1'b0;
            done_q       <= 1'b0;
            core_enable  <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            done_q       <= core_done;
            core_enable  <= 1'b0;
            digest_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            blk_buf     <= pad_blk;
                            byte_cnt    <= cnt_next;
                            need_pad    <= pad_overflow;
                            final_blk   <= ~pad_overflow;
                            pad80_owed  <= (w_idx == 4'd15) && (last_nbytes == 3'd4);
                            core_enable <= 1'b1;
                            state       <= START;
                        end else begin
                            for (int i = 0; i < 16; i++)
                                if (w_idx == 4'(i))
                                    blk_buf[511-32*i -: 32] <= in_data;
                            w_idx    <= w_idx + 4'd1;
                            byte_cnt <= byte_cnt + CNT_W'(4);
                            if (w_idx == 4'd15) begin
                                final_blk   <= 1'b0;
                                core_enable <= 1'b1;
                                state       <= START;
                            end
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a done left high from the previous block is ignored.
                    if (done_rise) begin
                        h <= core_hash;
                        if (final_blk) begin
                            state <= DONE;
                        end else if (need_pad) begin
                            state <= PADBLK;
                        end else begin
                            w_idx   <= '0;
                            blk_buf <= '0;
                            state   <= FILL;
                        end
                    end
                end
                PADBLK: begin
                    blk_buf     <= {(pad80_owed ? 8'h80 : 8'h00), 440'h0, len_cur};
                    final_blk   <= 1'b1;
                    need_pad    <= 1'b0;
                    pad80_owed  <= 1'b0;
                    core_enable <= 1'b1;
                    state       <= START;
                end
                DONE: begin
                    digest       <= h;
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                    h            <= SHA256_IV;
                    byte_cnt     <= '0;
                    w_idx        <= '0;
                    need_pad     <= 1'b0;
                    final_blk    <= 1'b0;
                    pad80_owed   <= 1'b0;
                    blk_buf      <= '0;
                    state        <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_feeder.sv
// Bench for sha256_feeder with a behavioural sha256 core model attached.
module tb_sha256_feeder;
    import sha256_pkg::*;

    localparam int LAT = 8;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_ABC_U = 256'hb5d4045c3f466fa91fe2cc6abe79232a1a57cdf104f7a26e716e0a1e2789df78;
    localparam logic [255:0] DIG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         core_enable;
    logic [511:0] core_data;
    logic [255:0] core_hash_in;
    logic [255:0] core_hash;
    logic         core_done;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    sha256_feeder #(.LEN_W(64)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .core_enable  (core_enable),
        .core_data    (core_data),
        .core_hash_in (core_hash_in),
        .core_hash    (core_hash),
        .core_done    (core_done),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   hh + hin[31:0]};
    endfunction

    // Core model: done rises LAT cycles after enable; in stale mode done stays high for the first cycles.
    bit           stale_mode = 1'b0;
    int           core_cnt;
    logic [511:0] core_blk_q;
    logic [255:0] core_h_q;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_done  <= 1'b0;
            core_cnt   <= 0;
            core_hash  <= '0;
            core_blk_q <= '0;
            core_h_q   <= '0;
        end else if (core_enable) begin
            core_blk_q <= core_data;
            core_h_q   <= core_hash_in;
            core_cnt   <= LAT;
            if (!stale_mode) core_done <= 1'b0;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == LAT - 3) core_done <= 1'b0;
            if (core_cnt == 1) begin
                core_done <= 1'b1;
                core_hash <= sha_compress(core_h_q, core_blk_q);
            end
        end
    end

    int           enable_cnt = 0;
    int           dv_cnt = 0;
    logic [511:0] blk_log [64];
    logic [255:0] hash_log [64];
    logic [255:0] digest_log [64];

    always @(negedge clk) begin
        if (core_enable) begin
            blk_log[enable_cnt[5:0]]  <= core_data;
            hash_log[enable_cnt[5:0]] <= core_hash_in;
            enable_cnt <= enable_cnt + 1;
        end
        if (digest_valid) begin
            digest_log[dv_cnt[5:0]] <= digest;
            dv_cnt <= dv_cnt + 1;
        end
    end

    typedef struct packed {
        int                n_words;
        logic [2:0]        last_bytes;
        logic [19:0][31:0] words;
        int                exp_blocks;
        logic              chk_digest;
        logic [255:0]      exp_digest;
        logic              chk_first;
        logic [511:0]      exp_first_blk;
        logic [511:0]      exp_last_blk;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int assertions = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sendWord(input logic [31:0] d, input logic last, input logic [2:0] nb, output int held);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        held = 0;
        while (!in_ready && held < 300) begin
            @(negedge clk);
            held++;
        end
        if (held >= 300) checkOutput("in_ready_timeout", 512'(held), 0);
        @(posedge clk);
    endtask

    task automatic applyStimulus(input int idx);
        int held;
        for (int j = 0; j < vecs[idx].n_words; j++) begin
            if (j == vecs[idx].n_words - 1)
                sendWord(vecs[idx].words[j], 1'b1, vecs[idx].last_bytes, held);
            else
                sendWord(vecs[idx].words[j], 1'b0, 3'd0, held);
        end
    endtask

    task automatic waitDigests(input int target, input string name);
        int cyc = 0;
        while (dv_cnt < target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (dv_cnt < target) checkOutput(name, 512'(dv_cnt), 512'(target));
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 512'(in_ready), 1);
        checkOutput({tag, "_core_enable"}, 512'(core_enable), 0);
        checkOutput({tag, "_digest_valid"}, 512'(digest_valid), 0);
        checkOutput({tag, "_busy"}, 512'(busy), 0);
        checkOutput({tag, "_digest"}, 512'(digest), 0);
        checkOutput({tag, "_core_data"}, core_data, 0);
        checkOutput({tag, "_core_hash_in"}, 512'(core_hash_in), 512'(SHA256_IV));
    endtask

    logic [31:0]  alpha [16] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h6f707172, 32'h70717273
    };
    logic [511:0] alpha_blk;

    initial begin
        int en0, dv0, held_a, held_b;

        for (int j = 0; j < 16; j++) alpha_blk[511-32*j -: 32] = alpha[j];

        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        // "abc"
        vecs[0].n_words = 1; vecs[0].last_bytes = 3'd3; vecs[0].words[0] = 32'h61626300;
        vecs[0].exp_blocks = 1; vecs[0].chk_digest = 1'b1; vecs[0].exp_digest = DIG_ABC;
        vecs[0].exp_last_blk = {32'h61626380, 416'h0, 64'h18};
        // empty message; the word content must be ignored
        vecs[1].n_words = 1; vecs[1].last_bytes = 3'd0; vecs[1].words[0] = 32'hdeadbeef;
        vecs[1].exp_blocks = 1; vecs[1].chk_digest = 1'b1; vecs[1].exp_digest = DIG_EMPTY;
        vecs[1].exp_last_blk = {32'h80000000, 480'h0};
        // 56 bytes: p = 56 spills the length into a pad block
        vecs[2].n_words = 14; vecs[2].last_bytes = 3'd4;
        for (int j = 0; j < 14; j++) vecs[2].words[j] = alpha[j];
        vecs[2].exp_blocks = 2; vecs[2].chk_digest = 1'b1; vecs[2].exp_digest = DIG_56;
        vecs[2].chk_first = 1'b1; vecs[2].exp_first_blk = {alpha_blk[511:64], 32'h80000000, 32'h0};
        vecs[2].exp_last_blk = {448'h0, 64'h1c0};
        // 55 bytes: p = 55 still fits, garbage low byte must be replaced by 0x80
        vecs[3].n_words = 14; vecs[3].last_bytes = 3'd3;
        for (int j = 0; j < 13; j++) vecs[3].words[j] = alpha[j];
        vecs[3].words[13] = 32'h6e6f70ff;
        vecs[3].exp_blocks = 1;
        vecs[3].exp_last_blk = {alpha_blk[511:96], 32'h6e6f7080, 64'h1b8};
        // 64 bytes: p = 64, the 0x80 moves to the pad block
        vecs[4].n_words = 16; vecs[4].last_bytes = 3'd4;
        for (int j = 0; j < 16; j++) vecs[4].words[j] = alpha[j];
        vecs[4].exp_blocks = 2; vecs[4].chk_first = 1'b1; vecs[4].exp_first_blk = alpha_blk;
        vecs[4].exp_last_blk = {32'h80000000, 416'h0, 64'h200};
        // 66 bytes: full continuation block then a short final block
        vecs[5].n_words = 17; vecs[5].last_bytes = 3'd2;
        for (int j = 0; j < 16; j++) vecs[5].words[j] = alpha[j];
        vecs[5].words[16] = 32'h11223344;
        vecs[5].exp_blocks = 2; vecs[5].chk_first = 1'b1; vecs[5].exp_first_blk = alpha_blk;
        vecs[5].exp_last_blk = {32'h11228000, 416'h0, 64'h210};
        // "ABC"
        vecs[6].n_words = 1; vecs[6].last_bytes = 3'd3; vecs[6].words[0] = 32'h41424300;
        vecs[6].exp_blocks = 1; vecs[6].chk_digest = 1'b1; vecs[6].exp_digest = DIG_ABC_U;
        vecs[6].exp_last_blk = {32'h41424380, 416'h0, 64'h18};

        n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = 3'd0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d: %0d words", i, vecs[i].n_words);
            en0 = enable_cnt;
            dv0 = dv_cnt;
            applyStimulus(i);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            checkOutput($sformatf("v%0d_enable_after_last", i), 512'(core_enable), 1);
            checkOutput($sformatf("v%0d_busy", i), 512'(busy), 1);
            waitDigests(dv0 + 1, $sformatf("v%0d_digest_timeout", i));
            checkOutput($sformatf("v%0d_blocks", i), 512'(enable_cnt - en0), 512'(vecs[i].exp_blocks));
            checkOutput($sformatf("v%0d_digest_pulses", i), 512'(dv_cnt - dv0), 1);
            checkOutput($sformatf("v%0d_first_hash_in", i), 512'(hash_log[en0[5:0]]), 512'(SHA256_IV));
            checkOutput($sformatf("v%0d_last_block", i), blk_log[(enable_cnt - 1) & 63], vecs[i].exp_last_blk);
            if (vecs[i].chk_first)
                checkOutput($sformatf("v%0d_first_block", i), blk_log[en0[5:0]], vecs[i].exp_first_blk);
            if (vecs[i].chk_digest)
                checkOutput($sformatf("v%0d_digest", i), 512'(digest_log[dv0[5:0]]), 512'(vecs[i].exp_digest));
            checkOutput($sformatf("v%0d_busy_after", i), 512'(busy), 0);
        end

        // Back-to-back "abc" with the next word held off and done left high from the last hash.
        $display("[TB] backpressure with stale done");
        stale_mode = 1'b1;
        en0 = enable_cnt;
        dv0 = dv_cnt;
        sendWord(32'h61626300, 1'b1, 3'd3, held_a);
        sendWord(32'h61626300, 1'b1, 3'd3, held_b);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitDigests(dv0 + 2, "stale_digest_timeout");
        stale_mode = 1'b0;
        checkOutput("stale_held_off", 512'(held_b >= LAT), 1);
        checkOutput("stale_blocks", 512'(enable_cnt - en0), 2);
        checkOutput("stale_digest_a", 512'(digest_log[dv0[5:0]]), 512'(DIG_ABC));
        checkOutput("stale_digest_b", 512'(digest_log[(dv0 + 1) & 63]), 512'(DIG_ABC));

        // Reset pulse while waiting on the core aborts the message.
        $display("[TB] reset during WAIT");
        dv0 = dv_cnt;
        sendWord(32'h61626300, 1'b1, 3'd3, held_a);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("abort_no_digest", 512'(dv_cnt - dv0), 0);
        sendWord(32'h61626300, 1'b1, 3'd3, held_a);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitDigests(dv0 + 1, "after_abort_timeout");
        checkOutput("after_abort_digest", 512'(digest_log[dv0[5:0]]), 512'(DIG_ABC));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sha256_feeder.md
# sha256_feeder

Message front-end for the `sha256` compression core. It accepts a byte-oriented message as a stream of 32-bit big-endian words and builds 512-bit blocks, including FIPS 180-4 padding and the 64-bit length field. It drives `enable`/`data`/`current_hash` into the core, chains each block's result into the next, and presents the final 256-bit digest. It sits between the host/scrypt datapath and `sha256`, doing what a testbench would otherwise do by hand.

## Interface
- `LEN_W`, 64: width of the message bit-length counter. Zero-extended into the 64-bit length field.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `in_valid` in 1: `in_data` word is valid.
- `in_ready` out 1: feeder accepts a word this cycle.
- `in_data` in 32: message word, first byte in bits [31:24].
- `in_last` in 1: final word of the message.
- `in_bytes` in 3: valid bytes in the last word (0–4), MSB-aligned. Ignored unless `in_last`. A value of 0 with `in_last` means no bytes, which allows the empty message.
- `core_enable` out 1: one-cycle start pulse to `sha256`.
- `core_data` out 512: block to the core, word 0 in bits [511:480].
- `core_hash_in` out 256: chaining value H to the core.
- `core_hash` in 256: `sha256.hash` result.
- `core_done` in 1: `sha256.hash_done`.
- `digest` out 256: final hash, held until the next message completes.
- `digest_valid` out 1: one-cycle pulse when `digest` updates.
- `busy` out 1: high from the first accepted word until `digest_valid`.

## Operation
- States: `FILL`, `START`, `WAIT`, `PADBLK`, `DONE`.
- **`FILL`**
  - `in_ready`=1.
  - Each accepted word is written to `buf[w_idx]`, `w_idx` is incremented, and `byte_cnt` is incremented by 4 (or by `in_bytes` when `in_last`).
  - 16th word without `in_last`: go to `START`, block not final.
- **`in_last` handling**
  - Valid bytes are kept, byte 0x80 is placed at the next byte position p (0–63 within the block), and the rest of the block is zeroed.
  - If p ≤ 55: words 14–15 ← `byte_cnt`×8 (64-bit). The block is final.
  - If p ≥ 56: the block is sent non-final and `need_pad` is set. If p = 64 (last word was full and was word 15), the 0x80 moves to byte 0 of the pad block.
- **`START`**
  - `core_enable`=1 for exactly one cycle.
  - `core_data`=buf. `core_hash_in`=H, where H = IV from the package for the first block of a message.
  - Go to `WAIT`.
- **`WAIT`**
  - Holds `core_data` and `core_hash_in` stable.
  - Advances on a rising edge of `core_done` (registered previous value), so a stale high `done` is ignored. On that edge, H ← `core_hash`.
  - Final block → `DONE`. `need_pad` → `PADBLK`. Otherwise → `FILL` with `w_idx`=0 and buf cleared.
- **`PADBLK`**
  - buf ← zeros, plus 0x80 at byte 0 if it is still owed, plus the length in words 14–15.
  - Mark final, clear `need_pad`, go to `START`.
- **`DONE`**
  - `digest` ← H, `digest_valid`=1.
  - Reset H to IV, clear `byte_cnt`, `w_idx` and flags, go to `FILL`.
- `in_ready`=0 in every state except `FILL`.
- `byte_cnt` wraps modulo 2^(LEN_W−3).

## Timing
- Reset values:
  - state `FILL`, H=IV, buf=0, `byte_cnt`=0, `w_idx`=0, `need_pad`=0.
  - `in_ready`=1 after reset; `core_enable`=0, `digest`=0, `digest_valid`=0, `busy`=0.
  - `core_data`=0, `core_hash_in`=IV.
- The last word accepted in `FILL` is followed by `core_enable` on the next cycle.
- `core_done` rise at cycle t gives `digest_valid` at t+2 for a final block, and `in_ready` high at t+1 for a continuation.
- Per-block overhead beyond the core latency: 2 cycles.
- Reset asserted mid-message or mid-`WAIT` aborts the message immediately. No `digest_valid` is produced. The core is reset by the same `n_rst`.
- `in_valid` asserted while `in_ready`=0 is held off. The upstream must keep the word stable.

## Structure
- `sha256_pkg`: `SHA256_IV` (8×32 constant), block/word/digest width localparams, state enum `feeder_state_t`.
- One sub-module, `sha256_pad_insert`: a combinational function of (buf, `w_idx`, last word, `in_bytes`, `byte_cnt`) → (padded block, p ≥ 56 flag). Its padding logic is unit-testable in isolation.

## Test plan
- **Empty message:** `in_last`=1, `in_bytes`=0 → `digest` e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, one core block.
- **"abc":** `in_data`=0x61626300, `in_bytes`=3, last → ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **"ABC":** 0x41424300, `in_bytes`=3 → b5d4045c 3f466fa9 1fe2cc6a be79232a 1a57cdf1 04f7a26e 716e0a1e 2789df78.
- **56-byte "abcdbcde…nopq":** 14 words, last with `in_bytes`=4 (p=56) → exactly 2 `core_enable` pulses, `digest` 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **Backpressure and stale done:** hold `in_valid` during `WAIT` and keep `core_done` high from the previous hash → no word is lost, no early advance, and the same "abc" digest results.
- **Reset mid-`WAIT`:** `n_rst` low for 1 cycle → all outputs return to their reset values and no `digest_valid` appears. A following "abc" gives the correct digest.
